// File: rtl/ov7670_dvp_emulator.sv
// OV7670-style DVP transmitter: replays an RGB565 frame buffer as vsync/href/byte
// stream with programmable blanking, high byte of each pixel first.
module ov7670_dvp_emulator #(
    parameter int H_ACTIVE      = 320,
    parameter int V_ACTIVE      = 240,
    parameter int H_BLANK       = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_PORCH  = 17,
    parameter int V_FRONT_PORCH = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    output logic        rd_en,
    output logic [16:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W    = $clog2(LINE_LEN);
    localparam int LN_MAX_A = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int LN_MAX_B = (V_BACK_PORCH > V_FRONT_PORCH) ? V_BACK_PORCH : V_FRONT_PORCH;
    localparam int LN_MAX   = (LN_MAX_A > LN_MAX_B) ? LN_MAX_A : LN_MAX_B;
    localparam int LN_W     = (LN_MAX > 1) ? $clog2(LN_MAX) : 1;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [LN_W-1:0]  ln_t;

    localparam col_t COL_LAST = col_t'(LINE_LEN - 1);
    localparam col_t COL_PREF = col_t'(LINE_LEN - 2);
    localparam col_t HREF_END = col_t'(2 * H_ACTIVE);
    localparam col_t PREF_END = col_t'(2 * H_ACTIVE - 2);
    localparam ln_t  LN_VS    = ln_t'(VSYNC_LINES - 1);
    localparam ln_t  LN_VBP   = ln_t'(V_BACK_PORCH - 1);
    localparam ln_t  LN_ACT   = ln_t'(V_ACTIVE - 1);
    localparam ln_t  LN_VFP   = ln_t'(V_FRONT_PORCH - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t      state, nxt_state;
    col_t        col, nxt_col;
    ln_t         ln, nxt_ln, ln_last;
    logic [15:0] pix, pix_nxt;
    logic        rd_pend;
    logic        nxt_href, nxt_rd;
    logic [7:0]  nxt_d;

    always_comb begin
        unique case (state)
            VSYNC:   ln_last = LN_VS;
            VBP:     ln_last = LN_VBP;
            ACTIVE:  ln_last = LN_ACT;
            VFP:     ln_last = LN_VFP;
            default: ln_last = '0;
        endcase
    end

    // Position (state, col, ln) that the registered outputs will describe next cycle.
    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_ln    = ln;
        if (state == IDLE) begin
            if (enable) nxt_state = VSYNC;
        end else if (col == COL_LAST) begin
            nxt_col = '0;
            if (ln == ln_last) begin
                nxt_ln = '0;
                unique case (state)
                    VSYNC:   nxt_state = VBP;
                    VBP:     nxt_state = ACTIVE;
                    ACTIVE:  nxt_state = VFP;
                    VFP:     nxt_state = enable ? VSYNC : IDLE;
                    default: nxt_state = IDLE;
                endcase
            end else begin
                nxt_ln = ln + 1'b1;
            end
        end else begin
            nxt_col = col + 1'b1;
        end
    end

    // Pixel k is fetched two columns before its high byte; pixel 0 comes from the previous line period.
    always_comb begin
        nxt_href = (nxt_state == ACTIVE) && (nxt_col < HREF_END);
        nxt_rd   = ((nxt_state == ACTIVE) && !nxt_col[0] && (nxt_col < PREF_END)) ||
                   ((nxt_col == COL_PREF) &&
                    (((nxt_state == VBP) && (nxt_ln == LN_VBP)) ||
                     ((nxt_state == ACTIVE) && (nxt_ln != LN_ACT))));
        pix_nxt  = rd_pend ? rd_data : pix;
        nxt_d    = 8'h00;
        if (nxt_href) nxt_d = nxt_col[0] ? pix_nxt[7:0] : pix_nxt[15:8];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            ln          <= '0;
            pix         <= '0;
            rd_pend     <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            d           <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt_state;
            col         <= nxt_col;
            ln          <= nxt_ln;
            pix         <= pix_nxt;
            rd_pend     <= rd_en;
            rd_en       <= nxt_rd;
            vsync       <= (nxt_state == VSYNC);
            href        <= nxt_href;
            d           <= nxt_d;
            frame_start <= (nxt_state == VSYNC) && (state != VSYNC);
            frame_done  <= (nxt_state == VFP) && (nxt_ln == LN_VFP) && (nxt_col == COL_LAST);
            busy        <= (nxt_state != IDLE);
            if ((nxt_state == VSYNC) && (state != VSYNC)) rd_addr <= '0;
            else if (rd_en)                               rd_addr <= rd_addr + 17'd1;
        end
    end

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// Bench for ov7670_dvp_emulator: per-frame expected cycle traces are queued when a
// frame is requested and compared cycle by cycle against the DUT outputs.
module tb_ov7670_dvp_emulator;

    localparam int HA     = 4;
    localparam int VA     = 3;
    localparam int HB     = 4;
    localparam int VSL    = 2;
    localparam int VBPL   = 1;
    localparam int VFPL   = 1;
    localparam int LL     = 2 * HA + HB;
    localparam int NLINES = VSL + VBPL + VA + VFPL;
    localparam int FLEN   = LL * NLINES;

    typedef struct {
        logic        vsync;
        logic        href;
        logic        rd_en;
        logic        fs;
        logic        fd;
        logic        busy;
        logic [7:0]  d;
        logic [16:0] addr;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [15:0] rd_data = 16'h0000;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    exp_t exp_q[$];
    logic chk_on = 1'b0;
    int   assert_cnt = 0;
    int   fail_cnt = 0;

    ov7670_dvp_emulator #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VSL), .V_BACK_PORCH(VBPL), .V_FRONT_PORCH(VFPL)
    ) dut (
        .pclk(pclk), .rst(rst), .enable(enable),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .vsync(vsync), .href(href), .d(d),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (rd_en) rd_data <= {4'hA, 1'b0, rd_addr[10:0]};
    end

    function automatic logic [15:0] word_at(input int a);
        logic [16:0] av;
        av = 17'(a);
        return {4'hA, 1'b0, av[10:0]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s at t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Whole-frame trace built from the frame geometry, one entry per pclk cycle.
    task automatic push_frame();
        exp_t        fr[FLEN];
        int          lnum, c, a, idx;
        logic [15:0] w;
        for (int i = 0; i < FLEN; i++) begin
            lnum = i / LL;
            c    = i % LL;
            a    = lnum - VSL - VBPL;
            fr[i].vsync = (lnum < VSL);
            fr[i].busy  = 1'b1;
            fr[i].fs    = (i == 0);
            fr[i].fd    = (i == FLEN - 1);
            fr[i].href  = (a >= 0) && (a < VA) && (c < 2 * HA);
            fr[i].rd_en = 1'b0;
            fr[i].addr  = 17'd0;
            fr[i].d     = 8'h00;
            if (fr[i].href) begin
                w = word_at(a * HA + c / 2);
                fr[i].d = (c % 2 == 0) ? w[15:8] : w[7:0];
            end
        end
        for (int v = 0; v < VA; v++) begin
            for (int k = 0; k < HA; k++) begin
                idx = (VSL + VBPL + v) * LL + 2 * k - 2;
                fr[idx].rd_en = 1'b1;
                fr[idx].addr  = 17'(v * HA + k);
            end
        end
        for (int i = 0; i < FLEN; i++) exp_q.push_back(fr[i]);
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(negedge pclk);
            #1;
        end
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (chk_on) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '{vsync: 1'b0, href: 1'b0, rd_en: 1'b0, fs: 1'b0, fd: 1'b0,
                      busy: 1'b0, d: 8'h00, addr: 17'd0};
            end
            check_output("vsync", 32'(vsync), 32'(e.vsync));
            check_output("href", 32'(href), 32'(e.href));
            check_output("d", 32'(d), 32'(e.d));
            check_output("rd_en", 32'(rd_en), 32'(e.rd_en));
            check_output("frame_start", 32'(frame_start), 32'(e.fs));
            check_output("frame_done", 32'(frame_done), 32'(e.fd));
            check_output("busy", 32'(busy), 32'(e.busy));
            if (e.rd_en) check_output("rd_addr", 32'(rd_addr), 32'(e.addr));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        apply_stimulus(2);
        chk_on = 1'b1;
        apply_stimulus(2);
        rst = 1'b0;
        apply_stimulus(3);

        $display("[TB] single frame from a one-cycle enable pulse");
        enable = 1'b1;
        push_frame();
        apply_stimulus(1);
        enable = 1'b0;
        apply_stimulus(FLEN + 4);

        $display("[TB] enable held: back-to-back frames");
        enable = 1'b1;
        push_frame();
        push_frame();
        apply_stimulus(FLEN + 40);
        enable = 1'b0;
        apply_stimulus(FLEN - 40 + 4);

        $display("[TB] enable dropped during active line 1");
        enable = 1'b1;
        push_frame();
        apply_stimulus(50);
        enable = 1'b0;
        apply_stimulus(FLEN + 4);

        $display("[TB] reset at active line 1 col 3, then fresh frame");
        enable = 1'b1;
        push_frame();
        apply_stimulus(52);
        rst = 1'b1;
        exp_q.delete();
        apply_stimulus(1);
        rst = 1'b0;
        push_frame();
        apply_stimulus(1);
        enable = 1'b0;
        apply_stimulus(FLEN + 4);

        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
